// File: rtl/exc_commit_pkg.sv
// rtl/exc_commit_pkg.sv - exception commit excodes, FSM states and interrupt helper
package exc_commit_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  function automatic logic int_pending(input logic [7:0] ip, input logic [7:0] im,
                                       input logic ie, input logic exl);
    return (|(ip & im)) && ie && !exl;
  endfunction

endpackage

// File: rtl/exc_commit_if.sv
// rtl/exc_commit_if.sv - MEM-to-WB instruction handshake bundle
interface exc_commit_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic        in_bd;
  logic        in_ex;
  logic [4:0]  in_excode;
  logic [31:0] in_badvaddr;
  logic        in_eret;

  modport master (
    output in_valid, in_pc, in_bd, in_ex, in_excode, in_badvaddr, in_eret,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_pc, in_bd, in_ex, in_excode, in_badvaddr, in_eret,
    output in_ready
  );
endinterface

// File: rtl/exc_commit_int_sync.sv
// rtl/exc_commit_int_sync.sv - two-flop synchronizer for the hardware interrupt lines
module exc_commit_int_sync (
  input  logic       clk,
  input  logic       resetn,
  input  logic [5:0] async_in,
  output logic [5:0] sync_out
);
  logic [5:0] meta;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta     <= '0;
      sync_out <= '0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end
endmodule

// File: rtl/exc_commit.sv
// rtl/exc_commit.sv - WB-stage exception/interrupt/ERET commit with flush handshake
module exc_commit
  import exc_commit_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  exc_commit_if.slave in_if,
  input  logic [5:0]  hw_int,
  input  logic [7:0]  status_im,
  input  logic        status_ie,
  input  logic        status_exl,
  input  logic [1:0]  sw_int,
  input  logic        flush_ack,
  output logic        wb_ex,
  output logic [4:0]  wb_excode,
  output logic [31:0] wb_pc,
  output logic        wb_bd,
  output logic [31:0] wb_badvaddr,
  output logic [7:0]  cause_ip,
  output logic        eret_flush,
  output logic        ws_valid
);
  state_e      state, state_nxt;
  logic [5:0]  sync_int;
  logic [31:0] ws_pc, ws_badvaddr;
  logic [4:0]  ws_excode;
  logic        ws_bd, ws_ex, ws_eret;
  logic        int_take, commit_ex, capture;

  exc_commit_int_sync u_int_sync (
    .clk      (clk),
    .resetn   (resetn),
    .async_in (hw_int),
    .sync_out (sync_int)
  );

  assign cause_ip   = {sync_int, sw_int};
  assign int_take   = int_pending(cause_ip, status_im, status_ie, status_exl);
  assign commit_ex  = ws_valid && (int_take || ws_ex);
  assign wb_ex      = commit_ex && (state == ST_RUN);
  assign eret_flush = ws_valid && ws_eret && !commit_ex && (state == ST_RUN);

  // While flushing we keep accepting so the front end drains; those instructions are dropped.
  assign in_if.in_ready = (state == ST_FLUSH) || !(ws_valid && (commit_ex || ws_eret));
  assign capture        = in_if.in_valid && in_if.in_ready && (state == ST_RUN);

  assign wb_excode   = int_take ? EXC_INT : ws_excode;
  assign wb_badvaddr = int_take ? 32'h0 : ws_badvaddr;
  assign wb_pc       = ws_pc;
  assign wb_bd       = ws_bd;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_RUN;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (wb_ex || eret_flush) state_nxt = ST_FLUSH;
      ST_FLUSH: if (flush_ack)           state_nxt = ST_RUN;
      default:                           state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid    <= 1'b0;
      ws_pc       <= '0;
      ws_bd       <= 1'b0;
      ws_ex       <= 1'b0;
      ws_excode   <= '0;
      ws_badvaddr <= '0;
      ws_eret     <= 1'b0;
    end else begin
      ws_valid <= capture;
      if (capture) begin
        ws_pc       <= in_if.in_pc;
        ws_bd       <= in_if.in_bd;
        ws_ex       <= in_if.in_ex;
        ws_excode   <= in_if.in_excode;
        ws_badvaddr <= in_if.in_badvaddr;
        ws_eret     <= in_if.in_eret;
      end
    end
  end
endmodule

// File: tb/tb_exc_commit.sv
// tb/tb_exc_commit.sv - self-checking bench for exc_commit
module tb_exc_commit;
  import exc_commit_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic [5:0]  hw_int;
  logic [7:0]  status_im;
  logic        status_ie, status_exl;
  logic [1:0]  sw_int;
  logic        flush_ack;
  logic        wb_ex, wb_bd, eret_flush, ws_valid;
  logic [4:0]  wb_excode;
  logic [31:0] wb_pc, wb_badvaddr;
  logic [7:0]  cause_ip;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic        bd;
    logic        ex;
    logic [4:0]  excode;
    logic [31:0] bad;
    logic        eret;
  } ins_t;

  exc_commit_if bus();

  exc_commit dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_if       (bus.slave),
    .hw_int      (hw_int),
    .status_im   (status_im),
    .status_ie   (status_ie),
    .status_exl  (status_exl),
    .sw_int      (sw_int),
    .flush_ack   (flush_ack),
    .wb_ex       (wb_ex),
    .wb_excode   (wb_excode),
    .wb_pc       (wb_pc),
    .wb_bd       (wb_bd),
    .wb_badvaddr (wb_badvaddr),
    .cause_ip    (cause_ip),
    .eret_flush  (eret_flush),
    .ws_valid    (ws_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_bd = 1'b0; bus.in_ex = 1'b0;
    bus.in_excode = '0; bus.in_badvaddr = '0; bus.in_eret = 1'b0;
  endtask

  task automatic drive(input ins_t i);
    bus.in_valid = 1'b1; bus.in_pc = i.pc; bus.in_bd = i.bd; bus.in_ex = i.ex;
    bus.in_excode = i.excode; bus.in_badvaddr = i.bad; bus.in_eret = i.eret;
  endtask

  task automatic ack_flush();
    tick(); idle(); flush_ack = 1'b1;
    tick(); flush_ack = 1'b0;
  endtask

  function automatic logic [4:0] pick_excode(input int unsigned r);
    case (r % 6)
      0: return EXC_ADEL;
      1: return EXC_ADES;
      2: return EXC_SYS;
      3: return EXC_BP;
      4: return EXC_RI;
      default: return EXC_OV;
    endcase
  endfunction

  task automatic test_reset();
    sample();
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_cmp++; if (wb_ex !== 1'b0) begin n_fail++; $display("FAIL reset_wb_ex got %b want 0", wb_ex); end
    n_cmp++; if (eret_flush !== 1'b0) begin n_fail++; $display("FAIL reset_eret got %b want 0", eret_flush); end
    n_cmp++; if (ws_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ws_valid got %b want 0", ws_valid); end
    n_cmp++; if (cause_ip !== 8'h02) begin n_fail++; $display("FAIL reset_cause_ip got %h want 02", cause_ip); end
    tick(); resetn = 1'b1; sw_int = 2'b00;
  endtask

  task automatic test_sys();
    tick(); drive('{pc: 32'hBFC00010, bd: 1'b0, ex: 1'b1, excode: EXC_SYS, bad: 32'h1234, eret: 1'b0});
    tick(); idle(); sample();
    n_cmp++; if (wb_ex !== 1'b1) begin n_fail++; $display("FAIL sys_wb_ex got %b want 1", wb_ex); end
    n_cmp++; if (wb_excode !== 5'h08) begin n_fail++; $display("FAIL sys_excode got %h want 08", wb_excode); end
    n_cmp++; if (wb_pc !== 32'hBFC00010) begin n_fail++; $display("FAIL sys_pc got %h want bfc00010", wb_pc); end
    n_cmp++; if (wb_bd !== 1'b0) begin n_fail++; $display("FAIL sys_bd got %b want 0", wb_bd); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL sys_stall got %b want 0", bus.in_ready); end
    tick(); drive('{pc: 32'h100, bd: 1'b0, ex: 1'b0, excode: 5'h0, bad: 32'h0, eret: 1'b0}); sample();
    n_cmp++; if (wb_ex !== 1'b0) begin n_fail++; $display("FAIL sys_single_pulse got %b want 0", wb_ex); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %b want 1", bus.in_ready); end
    tick(); idle(); sample();
    n_cmp++; if (ws_valid !== 1'b0) begin n_fail++; $display("FAIL flush_discard got %b want 0", ws_valid); end
    ack_flush();
    drive('{pc: 32'h200, bd: 1'b0, ex: 1'b0, excode: 5'h0, bad: 32'h0, eret: 1'b0});
    tick(); idle(); sample();
    n_cmp++; if (ws_valid !== 1'b1 || wb_pc !== 32'h200) begin n_fail++; $display("FAIL resume_capture got %b/%h want 1/00000200", ws_valid, wb_pc); end
    n_cmp++; if (wb_ex !== 1'b0) begin n_fail++; $display("FAIL resume_no_ex got %b want 0", wb_ex); end
    tick(); sample();
    n_cmp++; if (ws_valid !== 1'b0) begin n_fail++; $display("FAIL retire_drop got %b want 0", ws_valid); end
  endtask

  task automatic test_adel();
    tick(); drive('{pc: 32'h80000100, bd: 1'b1, ex: 1'b1, excode: EXC_ADEL, bad: 32'h3, eret: 1'b0});
    tick(); idle(); sample();
    n_cmp++; if (wb_ex !== 1'b1 || wb_excode !== 5'h04) begin n_fail++; $display("FAIL adel_excode got %b/%h want 1/04", wb_ex, wb_excode); end
    n_cmp++; if (wb_badvaddr !== 32'h3) begin n_fail++; $display("FAIL adel_badvaddr got %h want 00000003", wb_badvaddr); end
    n_cmp++; if (wb_bd !== 1'b1) begin n_fail++; $display("FAIL adel_bd got %b want 1", wb_bd); end
    ack_flush();
  endtask

  task automatic test_interrupt();
    tick(); status_im = 8'h04; status_ie = 1'b1; status_exl = 1'b0; hw_int = 6'h01; sample();
    n_cmp++; if (cause_ip !== 8'h00) begin n_fail++; $display("FAIL int_sync_early got %h want 00", cause_ip); end
    tick(); sample();
    n_cmp++; if (cause_ip !== 8'h00) begin n_fail++; $display("FAIL int_sync_one got %h want 00", cause_ip); end
    tick(); sample();
    n_cmp++; if (cause_ip !== 8'h04) begin n_fail++; $display("FAIL int_sync_two got %h want 04", cause_ip); end
    drive('{pc: 32'h300, bd: 1'b0, ex: 1'b1, excode: EXC_ADES, bad: 32'h55, eret: 1'b0});
    tick(); idle(); sample();
    n_cmp++; if (wb_ex !== 1'b1 || wb_excode !== EXC_INT) begin n_fail++; $display("FAIL int_commit got %b/%h want 1/00", wb_ex, wb_excode); end
    n_cmp++; if (wb_badvaddr !== 32'h0 || wb_pc !== 32'h300) begin n_fail++; $display("FAIL int_fields got %h/%h want 00000000/00000300", wb_badvaddr, wb_pc); end
    ack_flush();
    status_exl = 1'b1;
    drive('{pc: 32'h400, bd: 1'b0, ex: 1'b0, excode: 5'h0, bad: 32'h0, eret: 1'b0});
    tick(); idle(); sample();
    n_cmp++; if (wb_ex !== 1'b0 || ws_valid !== 1'b1) begin n_fail++; $display("FAIL int_exl got %b/%b want 0/1", wb_ex, ws_valid); end
    tick(); sample();
    n_cmp++; if (ws_valid !== 1'b0) begin n_fail++; $display("FAIL int_exl_retire got %b want 0", ws_valid); end
    hw_int = 6'h00; status_exl = 1'b0; status_ie = 1'b0; status_im = 8'h00;
    repeat (3) tick();
  endtask

  task automatic test_eret();
    drive('{pc: 32'h500, bd: 1'b0, ex: 1'b1, excode: EXC_RI, bad: 32'h0, eret: 1'b1});
    tick(); idle(); sample();
    n_cmp++; if (wb_ex !== 1'b1 || eret_flush !== 1'b0 || wb_excode !== 5'h0A) begin
      n_fail++; $display("FAIL eret_ri got %b/%b/%h want 1/0/0a", wb_ex, eret_flush, wb_excode); end
    ack_flush();
    drive('{pc: 32'h600, bd: 1'b0, ex: 1'b0, excode: 5'h0, bad: 32'h0, eret: 1'b1});
    tick(); drive('{pc: 32'h604, bd: 1'b0, ex: 1'b0, excode: 5'h0, bad: 32'h0, eret: 1'b0}); sample();
    n_cmp++; if (eret_flush !== 1'b1 || wb_ex !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL eret_plain got %b/%b/%b want 1/0/0", eret_flush, wb_ex, bus.in_ready); end
    tick(); sample();
    n_cmp++; if (eret_flush !== 1'b0 || ws_valid !== 1'b0) begin n_fail++; $display("FAIL eret_pulse got %b/%b want 0/0", eret_flush, ws_valid); end
    ack_flush();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      drive('{pc: 32'h1000 + 32'(4 * i), bd: 1'b0, ex: 1'b0, excode: 5'h0, bad: 32'h0, eret: 1'b0});
      tick(); sample();
      n_cmp++; if (bus.in_ready !== 1'b1 || ws_valid !== 1'b1 || wb_pc !== 32'h1000 + 32'(4 * i)) begin
        n_fail++; $display("FAIL b2b_%0d got %b/%b/%h want 1/1/%h", i, bus.in_ready, ws_valid, wb_pc, 32'h1000 + 32'(4 * i)); end
    end
    idle(); tick();
  endtask

  task automatic test_random();
    bit         m_flush = 1'b0, m_held = 1'b0, it, commit, eret_e, exp_ready;
    ins_t       m_ins = '0, nin;
    logic [5:0] hw_d1 = 6'h0, hw_d2 = 6'h0;
    logic [7:0] ip;
    for (int c = 0; c < 600; c++) begin
      tick();
      nin.pc = $urandom & 32'hFFFFFFFC; nin.bd = 1'($urandom);
      nin.ex = ($urandom % 5) == 0; nin.excode = pick_excode($urandom);
      nin.bad = $urandom; nin.eret = ($urandom % 6) == 0;
      if (($urandom % 4) != 0) drive(nin); else idle();
      if (($urandom % 12) == 0) hw_int = 6'($urandom);
      if (($urandom % 12) == 0) sw_int = 2'($urandom);
      if (($urandom % 10) == 0) status_im = 8'($urandom);
      if (($urandom % 10) == 0) status_ie = 1'($urandom);
      if (($urandom % 10) == 0) status_exl = 1'($urandom);
      flush_ack = ($urandom % 3) == 0;
      sample();
      ip        = {hw_d2, sw_int};
      it        = ((ip & status_im) != 0) && status_ie && !status_exl;
      commit    = !m_flush && m_held && (it || m_ins.ex);
      eret_e    = !m_flush && m_held && m_ins.eret && !commit;
      exp_ready = m_flush || !(m_held && (it || m_ins.ex || m_ins.eret));
      n_cmp++; if (cause_ip !== ip) begin n_fail++; $display("FAIL rnd_cause_ip c%0d got %h want %h", c, cause_ip, ip); end
      n_cmp++; if (wb_ex !== commit) begin n_fail++; $display("FAIL rnd_wb_ex c%0d got %b want %b", c, wb_ex, commit); end
      n_cmp++; if (eret_flush !== eret_e) begin n_fail++; $display("FAIL rnd_eret c%0d got %b want %b", c, eret_flush, eret_e); end
      n_cmp++; if (bus.in_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_in_ready c%0d got %b want %b", c, bus.in_ready, exp_ready); end
      n_cmp++; if (ws_valid !== m_held) begin n_fail++; $display("FAIL rnd_ws_valid c%0d got %b want %b", c, ws_valid, m_held); end
      if (commit) begin
        n_cmp++;
        if (wb_excode !== (it ? EXC_INT : m_ins.excode) || wb_pc !== m_ins.pc || wb_bd !== m_ins.bd ||
            wb_badvaddr !== (it ? 32'h0 : m_ins.bad)) begin
          n_fail++; $display("FAIL rnd_fields c%0d got %h/%h/%b/%h want %h/%h/%b/%h", c, wb_excode, wb_pc, wb_bd,
            wb_badvaddr, it ? EXC_INT : m_ins.excode, m_ins.pc, m_ins.bd, it ? 32'h0 : m_ins.bad);
        end
      end
      m_held = bus.in_valid && exp_ready && !m_flush;
      if (m_held) m_ins = nin;
      if (commit || eret_e) m_flush = 1'b1;
      else if (m_flush && flush_ack) m_flush = 1'b0;
      hw_d2 = hw_d1; hw_d1 = hw_int;
    end
    tick(); idle(); hw_int = 6'h0; sw_int = 2'b0; status_ie = 1'b0; flush_ack = 1'b1;
    repeat (3) tick();
    flush_ack = 1'b0;
  endtask

  task automatic test_reset_mid_flush();
    drive('{pc: 32'h680, bd: 1'b0, ex: 1'b1, excode: EXC_BP, bad: 32'h0, eret: 1'b0});
    tick(); idle();
    tick(); drive('{pc: 32'h690, bd: 1'b0, ex: 1'b0, excode: 5'h0, bad: 32'h0, eret: 1'b0}); sample();
    n_cmp++; if (ws_valid !== 1'b0 || wb_ex !== 1'b0) begin n_fail++; $display("FAIL midflush_state got %b/%b want 0/0", ws_valid, wb_ex); end
    #1 resetn = 1'b0;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1 || ws_valid !== 1'b0 || wb_ex !== 1'b0 || eret_flush !== 1'b0) begin
      n_fail++; $display("FAIL midflush_reset got %b/%b/%b/%b want 1/0/0/0", bus.in_ready, ws_valid, wb_ex, eret_flush); end
    tick(); resetn = 1'b1;
    drive('{pc: 32'h700, bd: 1'b0, ex: 1'b0, excode: 5'h0, bad: 32'h0, eret: 1'b0});
    tick(); idle(); sample();
    n_cmp++; if (ws_valid !== 1'b1 || wb_pc !== 32'h700 || wb_ex !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_run got %b/%h/%b want 1/00000700/0", ws_valid, wb_pc, wb_ex); end
    tick(); sample();
    n_cmp++; if (ws_valid !== 1'b0 || wb_ex !== 1'b0) begin n_fail++; $display("FAIL post_reset_retire got %b/%b want 0/0", ws_valid, wb_ex); end
  endtask

  initial begin
    resetn = 1'b0; hw_int = '0; status_im = '0; status_ie = 1'b0; status_exl = 1'b0;
    sw_int = 2'b10; flush_ack = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    test_reset();
    test_sys();
    test_adel();
    test_interrupt();
    test_eret();
    test_back_to_back();
    test_random();
    test_reset_mid_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
